// File: rtl/interface_circuit_multibyte.sv
`default_nettype none
// ============================================================================
// Module   : interface_circuit_multibyte
// Purpose  : UART <-> ALU bridge. Assembles multi-byte A/B operands and an
//            opcode from rx, then returns the ALU result MSB-first through tx.
//            Optional inter-byte timeout enabled by macro INTERBYTE_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module interface_circuit_multibyte #(
    parameter int WIDTH_WORD       = 8,
    parameter int BUS_DATOS_ALU    = 16,
    parameter int CANT_BITS_OPCODE = 6,
    parameter int BUS_SALIDA_ALU   = 16,
    parameter int TIMEOUT_CYCLES   = 1_000_000
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    input  logic [WIDTH_WORD-1:0]       i_data_rx,
    input  logic                        i_rx_done,
    input  logic                        i_tx_done,
    input  logic [BUS_SALIDA_ALU-1:0]   i_resultado_alu,
    output logic                        o_tx_start,
    output logic [WIDTH_WORD-1:0]       o_data_tx,
    output logic [BUS_DATOS_ALU-1:0]    o_reg_dato_A,
    output logic [BUS_DATOS_ALU-1:0]    o_reg_dato_B,
    output logic [CANT_BITS_OPCODE-1:0] o_reg_opcode,
    output logic [2:0]                  o_estado,
    output logic                        o_overrun,
    output logic                        o_error
);

    localparam int c_nb      = BUS_DATOS_ALU / WIDTH_WORD;
    localparam int c_nr      = (BUS_SALIDA_ALU + WIDTH_WORD - 1) / WIDTH_WORD;
    localparam int c_tx_w    = c_nr * WIDTH_WORD;
    localparam int c_cnt_max = (c_nb > c_nr) ? c_nb : c_nr;
    localparam int c_cnt_w   = (c_cnt_max > 1) ? $clog2(c_cnt_max) : 1;

    localparam logic [c_cnt_w-1:0] c_last_b = c_cnt_w'(c_nb - 1);
    localparam logic [c_cnt_w-1:0] c_last_r = c_cnt_w'(c_nr - 1);

    generate
        if ((BUS_DATOS_ALU % WIDTH_WORD) != 0 || BUS_DATOS_ALU < WIDTH_WORD) begin : g_chk_bus
            $error("BUS_DATOS_ALU must be a positive multiple of WIDTH_WORD");
        end
        if (CANT_BITS_OPCODE > WIDTH_WORD || CANT_BITS_OPCODE < 1) begin : g_chk_opcode
            $error("CANT_BITS_OPCODE must be in 1..WIDTH_WORD");
        end
        if (TIMEOUT_CYCLES < 1) begin : g_chk_timeout
            $error("TIMEOUT_CYCLES must be at least 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        RX_A    = 3'd0,
        RX_B    = 3'd1,
        RX_OP   = 3'd2,
        CAPTURE = 3'd3,
        TX_LOAD = 3'd4,
        TX_WAIT = 3'd5
    } state_t;

    state_t                   r_state;
    logic [c_cnt_w-1:0]       r_cnt;
    logic [BUS_DATOS_ALU-1:0] r_stage;
    logic [c_tx_w-1:0]        r_tx_shift;
    logic                     r_error;

    logic [BUS_DATOS_ALU-1:0] w_stage_next;
    logic [c_tx_w-1:0]        w_result_ext;
    logic                     w_tx_busy;

    // Shift-based append keeps the single-byte-operand case free of empty slices.
    assign w_stage_next = (r_stage << WIDTH_WORD) | BUS_DATOS_ALU'(i_data_rx);
    assign w_result_ext = c_tx_w'(i_resultado_alu);
    assign w_tx_busy    = (r_state == CAPTURE) || (r_state == TX_LOAD) || (r_state == TX_WAIT);
    assign o_estado     = r_state;

`ifdef INTERBYTE_TIMEOUT_EN
    localparam int c_tmo_w = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT_CYCLES - 1);

    logic [c_tmo_w-1:0] r_tmo;
    logic               w_mid_frame;

    assign w_mid_frame = ((r_state == RX_A) && (r_cnt != '0)) ||
                         (r_state == RX_B) || (r_state == RX_OP);
    assign o_error     = r_error;
`else
    assign o_error     = 1'b0;
`endif

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_state      <= RX_A;
            r_cnt        <= '0;
            r_stage      <= '0;
            r_tx_shift   <= '0;
            r_error      <= 1'b0;
            o_tx_start   <= 1'b0;
            o_data_tx    <= '0;
            o_reg_dato_A <= '0;
            o_reg_dato_B <= '0;
            o_reg_opcode <= '0;
            o_overrun    <= 1'b0;
`ifdef INTERBYTE_TIMEOUT_EN
            r_tmo        <= '0;
`endif
        end else begin
            o_tx_start <= 1'b0;
            r_error    <= 1'b0;

            case (r_state)
                RX_A: begin
                    if (i_rx_done) begin
                        if (r_cnt == c_last_b) begin
                            o_reg_dato_A <= w_stage_next;
                            r_stage      <= '0;
                            r_cnt        <= '0;
                            r_state      <= RX_B;
                        end else begin
                            r_stage <= w_stage_next;
                            r_cnt   <= r_cnt + c_cnt_w'(1);
                        end
                    end
                end
                RX_B: begin
                    if (i_rx_done) begin
                        if (r_cnt == c_last_b) begin
                            o_reg_dato_B <= w_stage_next;
                            r_stage      <= '0;
                            r_cnt        <= '0;
                            r_state      <= RX_OP;
                        end else begin
                            r_stage <= w_stage_next;
                            r_cnt   <= r_cnt + c_cnt_w'(1);
                        end
                    end
                end
                RX_OP: begin
                    if (i_rx_done) begin
                        o_reg_opcode <= i_data_rx[CANT_BITS_OPCODE-1:0];
                        r_cnt        <= '0;
                        r_state      <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    r_tx_shift <= w_result_ext;
                    r_cnt      <= '0;
                    r_state    <= TX_LOAD;
                end
                TX_LOAD: begin
                    o_data_tx  <= r_tx_shift[c_tx_w-1 -: WIDTH_WORD];
                    o_tx_start <= 1'b1;
                    r_state    <= TX_WAIT;
                end
                TX_WAIT: begin
                    // r_cnt counts bytes already sent across the LOAD/WAIT loop.
                    if (i_tx_done) begin
                        r_tx_shift <= r_tx_shift << WIDTH_WORD;
                        if (r_cnt == c_last_r) begin
                            r_cnt   <= '0;
                            r_state <= RX_A;
                        end else begin
                            r_cnt   <= r_cnt + c_cnt_w'(1);
                            r_state <= TX_LOAD;
                        end
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= RX_A;
                end
            endcase

            if (i_rx_done && w_tx_busy) begin
                o_overrun <= 1'b1;
            end

`ifdef INTERBYTE_TIMEOUT_EN
            // A byte arriving on the expiry cycle takes priority over the abort.
            if (i_rx_done || !w_mid_frame) begin
                r_tmo <= '0;
            end else if (r_tmo == c_tmo_last) begin
                r_tmo   <= '0;
                r_stage <= '0;
                r_cnt   <= '0;
                r_state <= RX_A;
                r_error <= 1'b1;
            end else begin
                r_tmo <= r_tmo + c_tmo_w'(1);
            end
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_interface_circuit_multibyte.sv
`default_nettype none
// ============================================================================
// Module   : tb_interface_circuit_multibyte
// Purpose  : Self-checking bench for 16-bit and 32-bit builds of the
//            UART/ALU bridge against a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_interface_circuit_multibyte;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    // 16-bit operand build
    logic [7:0]  rx_data, tx_data;
    logic        rx_done, tx_done, tx_start, overrun, err;
    logic [15:0] alu_res, reg_a, reg_b;
    logic [5:0]  reg_op;
    logic [2:0]  estado;
    logic [7:0]  tx_q[$];

    // 32-bit operand build
    logic [7:0]  rx_data32, tx_data32;
    logic        rx_done32, tx_done32, tx_start32, overrun32, err32;
    logic [31:0] alu_res32, reg_a32, reg_b32;
    logic [5:0]  reg_op32;
    logic [2:0]  estado32;
    logic [7:0]  tx_q32[$];

    function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [5:0] op);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            6'h27:   return ~(a | b);
            default: return 32'h0;
        endcase
    endfunction

    assign alu_res   = 16'(alu_model({16'h0, reg_a}, {16'h0, reg_b}, reg_op));
    assign alu_res32 = alu_model(reg_a32, reg_b32, reg_op32);

    interface_circuit_multibyte #(
        .WIDTH_WORD(8), .BUS_DATOS_ALU(16), .CANT_BITS_OPCODE(6),
        .BUS_SALIDA_ALU(16), .TIMEOUT_CYCLES(100)
    ) dut (
        .i_clock(clk), .i_reset(rst_n), .i_data_rx(rx_data), .i_rx_done(rx_done),
        .i_tx_done(tx_done), .i_resultado_alu(alu_res), .o_tx_start(tx_start),
        .o_data_tx(tx_data), .o_reg_dato_A(reg_a), .o_reg_dato_B(reg_b),
        .o_reg_opcode(reg_op), .o_estado(estado), .o_overrun(overrun), .o_error(err)
    );

    interface_circuit_multibyte #(
        .WIDTH_WORD(8), .BUS_DATOS_ALU(32), .CANT_BITS_OPCODE(6),
        .BUS_SALIDA_ALU(32), .TIMEOUT_CYCLES(100)
    ) dut32 (
        .i_clock(clk), .i_reset(rst_n), .i_data_rx(rx_data32), .i_rx_done(rx_done32),
        .i_tx_done(tx_done32), .i_resultado_alu(alu_res32), .o_tx_start(tx_start32),
        .o_data_tx(tx_data32), .o_reg_dato_A(reg_a32), .o_reg_dato_B(reg_b32),
        .o_reg_opcode(reg_op32), .o_estado(estado32), .o_overrun(overrun32), .o_error(err32)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Models the tx UART: accepts a start, holds busy 3 cycles, then acknowledges.
    initial begin : resp16
        logic [7:0] b;
        tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start === 1'b1) begin
                b = tx_data;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    check("tx_start_while_busy", {31'h0, tx_start}, 32'h0);
                    check("tx_data_hold", {24'h0, tx_data}, {24'h0, b});
                end
                tx_q.push_back(b);
                tx_done = 1'b1;
                @(negedge clk);
                tx_done = 1'b0;
            end
        end
    end

    initial begin : resp32
        logic [7:0] b;
        tx_done32 = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start32 === 1'b1) begin
                b = tx_data32;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    check("tx32_start_while_busy", {31'h0, tx_start32}, 32'h0);
                    check("tx32_data_hold", {24'h0, tx_data32}, {24'h0, b});
                end
                tx_q32.push_back(b);
                tx_done32 = 1'b1;
                @(negedge clk);
                tx_done32 = 1'b0;
            end
        end
    end

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic send32(input logic [7:0] b);
        @(negedge clk);
        rx_data32 = b;
        rx_done32 = 1'b1;
        @(negedge clk);
        rx_done32 = 1'b0;
    endtask

    task automatic wait_idle16();
        int n = 0;
        while (estado !== 3'd0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("return_to_rx_a", {29'h0, estado}, 32'h0);
    endtask

    // Full 16-bit frame; optionally the first byte was already sent, optionally
    // a stray byte is injected once transmission has begun.
    task automatic frame16(input logic [15:0] a, input logic [15:0] b, input logic [7:0] opb,
                           input bit first_sent, input bit inject);
        logic [15:0] res;
        int          lat;
        int          n;
        tx_q.delete();
        if (!first_sent) send(a[15:8]);
        send(a[7:0]);
        send(b[15:8]);
        send(b[7:0]);
        send(opb);
        check("reg_a", {16'h0, reg_a}, {16'h0, a});
        check("reg_b", {16'h0, reg_b}, {16'h0, b});
        check("reg_opcode", {26'h0, reg_op}, {26'h0, opb[5:0]});
        lat = 0;
        while (tx_start !== 1'b1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check("first_tx_latency", lat, 2);
        if (inject) begin
            check("state_tx_wait", {29'h0, estado}, 32'd5);
            rx_data = 8'hFF;
            rx_done = 1'b1;
            @(negedge clk);
            rx_done = 1'b0;
            check("overrun_set", {31'h0, overrun}, 32'h1);
        end
        n = 0;
        while (tx_q.size() < 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("tx_byte_count", tx_q.size(), 2);
        res = 16'(alu_model({16'h0, a}, {16'h0, b}, opb[5:0]));
        if (tx_q.size() == 2) begin
            check("tx_byte_msb", {24'h0, tx_q[0]}, {24'h0, res[15:8]});
            check("tx_byte_lsb", {24'h0, tx_q[1]}, {24'h0, res[7:0]});
        end
        wait_idle16();
        check("reg_a_after_tx", {16'h0, reg_a}, {16'h0, a});
    endtask

    task automatic frame32(input logic [31:0] a, input logic [31:0] b, input logic [7:0] opb);
        logic [31:0] res;
        int          n;
        tx_q32.delete();
        for (int i = 3; i >= 0; i--) send32(8'(a >> (8 * i)));
        for (int i = 3; i >= 0; i--) send32(8'(b >> (8 * i)));
        send32(opb);
        check("reg_a32", reg_a32, a);
        check("reg_b32", reg_b32, b);
        check("reg_opcode32", {26'h0, reg_op32}, {26'h0, opb[5:0]});
        n = 0;
        while ((tx_q32.size() < 4 || estado32 !== 3'd0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("tx32_byte_count", tx_q32.size(), 4);
        res = alu_model(a, b, opb[5:0]);
        for (int i = 0; i < 4 && i < tx_q32.size(); i++) begin
            check("tx32_byte", {24'h0, tx_q32[i]}, {24'h0, 8'(res >> (8 * (3 - i)))});
        end
        check("state32_rx_a", {29'h0, estado32}, 32'h0);
    endtask

    task automatic check_reset_state16();
        check("rst_reg_a", {16'h0, reg_a}, 32'h0);
        check("rst_reg_b", {16'h0, reg_b}, 32'h0);
        check("rst_opcode", {26'h0, reg_op}, 32'h0);
        check("rst_estado", {29'h0, estado}, 32'h0);
        check("rst_tx_start_data", {23'h0, tx_start, tx_data}, 32'h0);
        check("rst_overrun_error", {30'h0, overrun, err}, 32'h0);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [7:0]  ops[6];
        logic [15:0] prev_a;
        logic [7:0]  opb;
        int          cyc;
        int          pulses;
        ops = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27};

        rst_n = 1'b0;
        rx_data = '0;   rx_done = 1'b0;
        rx_data32 = '0; rx_done32 = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state16();
        check("rst32_regs", reg_a32 | reg_b32, 32'h0);
        check("rst32_estado_overrun", {28'h0, estado32, overrun32}, 32'h0);
        rst_n = 1'b1;

        // Basic ADD frame
        frame16(16'h1234, 16'h0005, 8'h20, 1'b0, 1'b0);
        check("no_overrun_yet", {31'h0, overrun}, 32'h0);

        // Stray byte during transmission
        frame16(16'h00A5, 16'h0101, 8'h20, 1'b0, 1'b1);
        check("overrun_sticky", {31'h0, overrun}, 32'h1);

        // Reset mid-operand clears everything, including the sticky overrun
        send(8'hAB);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_reset_state16();
        frame16(16'h0001, 16'h0002, 8'h20, 1'b0, 1'b0);

        // Opcode upper bits dropped
        frame16(16'h0001, 16'h0002, 8'hE0, 1'b0, 1'b0);
        check("opcode_masked", {26'h0, reg_op}, 32'h20);

        // Inter-byte gap
        prev_a = reg_a;
        send(8'h12);
        cyc = 0;
        pulses = 0;
        for (int i = 1; i <= 150; i++) begin
            @(negedge clk);
            if (err === 1'b1) begin
                pulses++;
                if (cyc == 0) cyc = i;
            end
        end
`ifdef INTERBYTE_TIMEOUT_EN
        check("timeout_cycle", cyc, 100);
        check("timeout_pulses", pulses, 1);
        check("timeout_state", {29'h0, estado}, 32'h0);
        check("timeout_keeps_a", {16'h0, reg_a}, {16'h0, prev_a});
        frame16(16'h1234, 16'h0005, 8'h20, 1'b0, 1'b0);
`else
        check("no_error_pulses", pulses, 0);
        check("gap_state_rx_a", {29'h0, estado}, 32'h0);
        check("gap_keeps_a", {16'h0, reg_a}, {16'h0, prev_a});
        frame16(16'h1234, 16'h0005, 8'h20, 1'b1, 1'b0);
`endif

        // Randomised frames
        for (int i = 0; i < 6; i++) begin
            opb = ops[$urandom_range(0, 5)] | 8'(($urandom_range(0, 3)) << 6);
            frame16(16'($urandom), 16'($urandom), opb, 1'b0, 1'b0);
        end

        // 32-bit operands and result
        frame32(32'h01020304, 32'h00000001, 8'h20);
        check("overrun32_clear", {31'h0, overrun32}, 32'h0);
        for (int i = 0; i < 2; i++) begin
            opb = ops[$urandom_range(0, 5)];
            frame32($urandom, $urandom, opb);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/interface_circuit_multibyte.md
Name: interface_circuit_multibyte

Overview:
Parametrised successor to the single-byte UART/ALU interface circuit. Sits between the rx/tx UART modules and the combinational alu. Assembles multi-byte operands A and B plus a one-byte opcode from the received byte stream, then captures the ALU result and returns it as a multi-byte, MSB-first sequence through tx. Adds overrun flagging and an optional inter-byte timeout.

Parameters:
WIDTH_WORD, 8, UART word width in bits.
BUS_DATOS_ALU, 16, operand width in bits; must be an integer multiple of WIDTH_WORD (elaboration constraint).
CANT_BITS_OPCODE, 6, opcode width in bits; must be <= WIDTH_WORD; taken from the low bits of the opcode byte.
BUS_SALIDA_ALU, 16, result width in bits; sent as ceil(BUS_SALIDA_ALU/WIDTH_WORD) bytes, MSB byte zero-padded.
TIMEOUT_CYCLES, 1_000_000, inter-byte timeout in clock cycles; used only with the optional feature.

Ports:
i_clock  in  1  system clock.
i_reset  in  1  synchronous, active-low reset.
i_data_rx  in  WIDTH_WORD  byte from rx; valid when i_rx_done=1.
i_rx_done  in  1  one-cycle pulse per received byte.
i_tx_done  in  1  one-cycle pulse when tx finishes a byte.
i_resultado_alu  in  BUS_SALIDA_ALU  combinational ALU result.
o_tx_start  out  1  one-cycle pulse to start a tx byte.
o_data_tx  out  WIDTH_WORD  byte to transmit; held stable from o_tx_start until i_tx_done.
o_reg_dato_A  out  BUS_DATOS_ALU  operand A to the ALU.
o_reg_dato_B  out  BUS_DATOS_ALU  operand B to the ALU.
o_reg_opcode  out  CANT_BITS_OPCODE  opcode to the ALU.
o_estado  out  3  current state encoding, for LEDs.
o_overrun  out  1  sticky flag: a byte arrived while transmitting.
o_error  out  1  one-cycle pulse on timeout abort.

Behaviour:
- Reset: all outputs 0 and state RX_A, applied on the first rising edge with i_reset=0. Reset overrides everything, including mid-frame and mid-transmission.
- NB = BUS_DATOS_ALU/WIDTH_WORD and NR = ceil(BUS_SALIDA_ALU/WIDTH_WORD). A byte counter is cleared on every state entry.
- RX_A:
  - Each i_rx_done shifts i_data_rx into the A staging register, MSB byte first.
  - On the NB-th byte, the full word is loaded into o_reg_dato_A on that same edge, then the state goes to RX_B.
- RX_B: same as RX_A, loading o_reg_dato_B on the NB-th byte, then the state goes to RX_OP.
- RX_OP:
  - i_rx_done loads i_data_rx[CANT_BITS_OPCODE-1:0] into o_reg_opcode; the upper bits are ignored.
  - State goes to CAPTURE.
- CAPTURE (1 cycle): i_resultado_alu, zero-extended to NR*WIDTH_WORD, is loaded into the tx shift register; state goes to TX_LOAD.
- TX_LOAD (1 cycle):
  - o_data_tx is set to the current MSB byte and o_tx_start=1 for this cycle only.
  - State goes to TX_WAIT.
- TX_WAIT:
  - On i_tx_done, the shift register moves left by WIDTH_WORD.
  - If bytes sent < NR, state goes to TX_LOAD; else state goes to RX_A.
- Latency: the first o_tx_start pulse occurs exactly 2 cycles after the edge that samples the opcode byte's i_rx_done.
- A, B and opcode outputs hold their values until overwritten by the next frame; the A/B staging registers are separate, so the ALU inputs never show partial words.
- i_rx_done during CAPTURE, TX_LOAD or TX_WAIT: the byte is dropped and o_overrun is set to 1 (sticky until reset).
- i_tx_done outside TX_WAIT is ignored.
- o_estado encoding: RX_A=0, RX_B=1, RX_OP=2, CAPTURE=3, TX_LOAD=4, TX_WAIT=5.

Optional Feature:
INTERBYTE_TIMEOUT_EN
- Defined:
  - A counter runs while the FSM is mid-frame: in RX_A with byte count > 0, or in RX_B or RX_OP. It resets to 0 on each i_rx_done.
  - When the counter reaches TIMEOUT_CYCLES-1 with no byte: staging registers and counters are cleared, state goes to RX_A, and o_error pulses for 1 cycle.
  - o_reg_dato_A/B/opcode keep their previous values.
  - If i_rx_done arrives in the same cycle as the timeout, the byte wins and no abort occurs.
- Not defined: no counter is built, o_error is tied to 0, and the FSM waits indefinitely.

Test Plan:
1. Defaults, bench ALU models ADD for opcode 0x20. Send 0x12,0x34,0x00,0x05,0x20 -> A=0x1234, B=0x0005, opcode=0x20. tx emits 0x12 then 0x39 (one o_tx_start per byte, second only after i_tx_done), then state returns to RX_A.
2. Reset low after receiving 0xAB (mid-A) -> all outputs 0. Then a full frame 0x00,0x01,0x00,0x02,0x20 yields tx bytes 0x00,0x03.
3. Pulse i_rx_done with 0xFF during TX_WAIT -> o_overrun=1. The byte does not appear in A, and the tx sequence completes unchanged.
4. Send 0x00,0x01,0x00,0x02,0xE0 -> o_reg_opcode=0x20 (upper bits dropped). The first o_tx_start occurs exactly 2 cycles after the opcode's i_rx_done edge.
5. With INTERBYTE_TIMEOUT_EN and TIMEOUT_CYCLES=100: send 0x12, then wait 100 cycles -> o_error pulses once and state is RX_A. A following full frame decodes correctly.
6. With BUS_DATOS_ALU=32 and BUS_SALIDA_ALU=32: send 4+4+1 bytes, A=0x01020304, B=0x00000001, ADD -> tx bytes 0x01,0x02,0x03,0x05.
